// File: rtl/zuse_pkg.sv
// Shared definitions for the Zuse FPU host link: wire opcodes, operand field widths
// and the encoding of the host sequencer states.
package zuse_pkg;

    localparam int EXP_W = 7;
    localparam int MAN_W = 15;

    localparam logic [7:0] CMD_SETR1  = 8'h81;
    localparam logic [7:0] CMD_SETR2  = 8'h82;
    localparam logic [7:0] CMD_READRS = 8'h85;
    localparam logic [7:0] CMD_ADD    = 8'h89;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ADDW      = 3'd4,
        ST_RECV      = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

endpackage

// File: rtl/zuse_byte_pack.sv
// Combinational operand-to-wire byte mapper: field 0 is {0,exp}, 1 is man[14:7],
// 2 is {man[6:0],0}; zero latency, no flow control.
module zuse_byte_pack
    import zuse_pkg::*;
(
    input  logic [EXP_W-1:0] i_exp,
    input  logic [MAN_W-1:0] i_man,
    input  logic [1:0]       i_idx,
    output logic [7:0]       o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_idx)
            2'd0:    o_byte = {1'b0, i_exp};
            2'd1:    o_byte = i_man[MAN_W-1:MAN_W-8];
            2'd2:    o_byte = {i_man[MAN_W-9:0], 1'b0};
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/zuse_host_initiator.sv
// Drives one FPU add over a byte UART: loads R1/R2, issues ADD, waits, reads the result.
// Each byte waits for tx_busy low before its strobe; any stalled handshake or rx byte aborts after TIMEOUT cycles.
module zuse_host_initiator
    import zuse_pkg::*;
#(
    parameter int ADD_WAIT = 64,
    parameter int TIMEOUT  = 50000
) (
    input  logic        clk_10MHZ,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  a_e,
    input  logic [14:0] a_m,
    input  logic [6:0]  b_e,
    input  logic [14:0] b_m,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [6:0]  res_e,
    output logic [14:0] res_m,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // The WAIT_DONE exit and the SEND cycle complete the ADD_WAIT gap, so ADDW itself is three cycles shorter.
    localparam logic [15:0] ADDW_LAST = 16'(ADD_WAIT - 3);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [3:0]       r_idx;
    logic [15:0]      r_cnt;
    logic [1:0]       r_rx_idx;
    logic [EXP_W-1:0] r_rx_e;
    logic [7:0]       r_rx_mh;
    logic [EXP_W-1:0] r_a_e;
    logic [MAN_W-1:0] r_a_m;
    logic [EXP_W-1:0] r_b_e;
    logic [MAN_W-1:0] r_b_m;
    logic [7:0]       r_tx_data;
    logic             r_tx_start;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [EXP_W-1:0] r_res_e;
    logic [MAN_W-1:0] r_res_m;

    logic             w_accept;
    logic             w_to_hit;
    logic             w_sel_b;
    logic [1:0]       w_field_idx;
    logic [EXP_W-1:0] w_pack_exp;
    logic [MAN_W-1:0] w_pack_man;
    logic [7:0]       w_pack_byte;
    logic [7:0]       w_tx_byte;

    // A start landing on the done pulse is dropped even though the state already reads IDLE.
    assign w_accept    = (r_state == ST_IDLE) && start && !r_done;
    assign w_to_hit    = (r_cnt == TO_LAST);
    assign w_sel_b     = (r_idx > 4'd4);
    assign w_field_idx = w_sel_b ? 2'(r_idx - 4'd5) : 2'(r_idx - 4'd1);
    assign w_pack_exp  = w_sel_b ? r_b_e : r_a_e;
    assign w_pack_man  = w_sel_b ? r_b_m : r_a_m;

    zuse_byte_pack u_pack (
        .i_exp  (w_pack_exp),
        .i_man  (w_pack_man),
        .i_idx  (w_field_idx),
        .o_byte (w_pack_byte)
    );

    always_comb begin
        w_tx_byte = w_pack_byte;
        case (r_idx)
            4'd0:    w_tx_byte = CMD_SETR1;
            4'd4:    w_tx_byte = CMD_SETR2;
            4'd8:    w_tx_byte = CMD_ADD;
            4'd9:    w_tx_byte = CMD_READRS;
            default: w_tx_byte = w_pack_byte;
        endcase
    end

    always_ff @(posedge clk_10MHZ) begin
        if (w_accept) begin
            r_a_e <= a_e;
            r_a_m <= a_m;
            r_b_e <= b_e;
            r_b_m <= b_m;
        end
    end

    always_ff @(posedge clk_10MHZ) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= 4'd0;
            r_cnt      <= 16'd0;
            r_rx_idx   <= 2'd0;
            r_rx_e     <= '0;
            r_rx_mh    <= 8'd0;
            r_tx_data  <= 8'd0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_res_e    <= '0;
            r_res_m    <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cnt      <= r_cnt + 16'd1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_busy   <= 1'b1;
                        r_idx    <= 4'd0;
                        r_rx_idx <= 2'd0;
                        r_cnt    <= 16'd0;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        r_tx_data  <= w_tx_byte;
                        r_tx_start <= 1'b1;
                        r_cnt      <= 16'd0;
                        r_state    <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        r_cnt   <= 16'd0;
                        r_state <= ST_WAIT_DONE;
                    end else if (w_to_hit) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= 16'd0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_idx <= r_idx + 4'd1;
                        r_cnt <= 16'd0;
                        if (r_idx == 4'd8)
                            r_state <= ST_ADDW;
                        else if (r_idx == 4'd9)
                            r_state <= ST_RECV;
                        else
                            r_state <= ST_SEND;
                    end else if (w_to_hit) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= 16'd0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ADDW: begin
                    if (r_cnt == ADDW_LAST) begin
                        r_cnt   <= 16'd0;
                        r_state <= ST_SEND;
                    end
                end
                ST_RECV: begin
                    if (rx_done) begin
                        r_cnt <= 16'd0;
                        case (r_rx_idx)
                            2'd0: begin
                                r_rx_e   <= rx_data[6:0];
                                r_rx_idx <= 2'd1;
                            end
                            2'd1: begin
                                r_rx_mh  <= rx_data;
                                r_rx_idx <= 2'd2;
                            end
                            default: begin
                                r_res_e  <= r_rx_e;
                                r_res_m  <= {r_rx_mh, rx_data[7:1]};
                                r_rx_idx <= 2'd0;
                                r_state  <= ST_DONE;
                            end
                        endcase
                    end else if (w_to_hit) begin
                        r_done  <= 1'b1;
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= 16'd0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= 16'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= 16'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign res_e    = r_res_e;
    assign res_m    = r_res_m;

endmodule

// File: tb/tb_zuse_host_initiator.sv
// Self-checking bench for zuse_host_initiator: table vectors, random transactions against
// an arithmetic reference model, and hand sequences for disturbance, reset and timeout.
module tb_zuse_host_initiator;

    localparam int ADD_WAIT = 64;
    localparam int TIMEOUT  = 50000;

    logic        clk_10MHZ = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  a_e, b_e;
    logic [14:0] a_m, b_m;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [6:0]  res_e;
    logic [14:0] res_m;
    logic        busy, done, error;

    zuse_host_initiator #(.ADD_WAIT(ADD_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk_10MHZ (clk_10MHZ),
        .rst_n     (rst_n),
        .start     (start),
        .a_e       (a_e),
        .a_m       (a_m),
        .b_e       (b_e),
        .b_m       (b_m),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .res_e     (res_e),
        .res_m     (res_m),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #50 clk_10MHZ = ~clk_10MHZ;

    typedef struct {
        logic [6:0]  ae;
        logic [14:0] am;
        logic [6:0]  be;
        logic [14:0] bm;
        logic [7:0]  r0, r1, r2;
        logic [79:0] exp_tx;
        logic [6:0]  exp_e;
        logic [14:0] exp_m;
    } vec_t;

    vec_t vecs[4];

    int n_tests = 0;
    int n_fail  = 0;

    // Transmitter model and output monitor state
    int          cyc = 0;
    int          busy_len_cfg = 10;
    int          busy_left = 0;
    logic [7:0]  held_byte = 8'h00;
    bit          hold_bad = 1'b0;
    logic [7:0]  tx_q[$];
    int          strobe_q[$];
    int          fall_q[$];
    logic [23:0] done_q[$];
    int          done_cyc_q[$];

    logic [6:0]  last_e = 7'd0;
    logic [14:0] last_m = 15'd0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] model_tx(input int ae, input int am, input int be, input int bm);
        int          seq[10];
        logic [79:0] v;
        seq = '{129, ae, am / 128, (am % 128) * 2, 130, be, bm / 128, (bm % 128) * 2, 137, 133};
        v = '0;
        for (int i = 0; i < 10; i++) v = {v[71:0], 8'(seq[i])};
        return v;
    endfunction

    function automatic logic [21:0] model_res(input int r0, input int r1, input int r2);
        int e, m;
        e = r0 % 128;
        m = r1 * 128 + r2 / 2;
        return {7'(e), 15'(m)};
    endfunction

    // Transmitter: tx_busy rises on the strobe and stays high busy_len_cfg cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk_10MHZ); #1;
            cyc++;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_busy = 1'b0;
                    fall_q.push_back(cyc);
                end
            end
            if (tx_start === 1'b1) begin
                tx_q.push_back(tx_data);
                strobe_q.push_back(cyc);
                held_byte = tx_data;
                tx_busy   = 1'b1;
                busy_left = busy_len_cfg;
            end else if (tx_busy && tx_data !== held_byte) begin
                hold_bad = 1'b1;
            end
            if (done === 1'b1) begin
                done_q.push_back({error, busy, res_e, res_m});
                done_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        tx_q.delete();
        strobe_q.delete();
        fall_q.delete();
        done_q.delete();
        done_cyc_q.delete();
        hold_bad = 1'b0;
    endtask

    task automatic send_rx_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin @(posedge clk_10MHZ); #1; end
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk_10MHZ); #1;
        rx_done = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input int blen, input bit send_rx, input bit disturb, input bit start_on_done);
        clear_logs();
        busy_len_cfg = blen;
        @(posedge clk_10MHZ); #1;
        a_e = v.ae; a_m = v.am; b_e = v.be; b_m = v.bm;
        start = 1'b1;
        @(posedge clk_10MHZ); #1;
        start = 1'b0;
        if (disturb) begin
            for (int k = 0; k < 2000 && tx_q.size() < 3; k++) begin @(posedge clk_10MHZ); #1; end
            start = 1'b1;
            a_e = ~v.ae; a_m = ~v.am; b_e = ~v.be; b_m = ~v.bm;
            rx_data = 8'h99;
            rx_done = 1'b1;
            @(posedge clk_10MHZ); #1;
            start   = 1'b0;
            rx_done = 1'b0;
        end
        for (int k = 0; k < 4000 && fall_q.size() < 10; k++) begin @(posedge clk_10MHZ); #1; end
        if (send_rx) begin
            repeat (2) begin @(posedge clk_10MHZ); #1; end
            send_rx_byte(v.r0, $urandom_range(0, 3));
            send_rx_byte(v.r1, $urandom_range(0, 3));
            send_rx_byte(v.r2, $urandom_range(0, 3));
        end
        for (int k = 0; k < (send_rx ? 1000 : TIMEOUT + 200) && done !== 1'b1; k++) begin
            @(posedge clk_10MHZ); #1;
        end
        if (start_on_done && done === 1'b1) begin
            start = 1'b1;
            @(posedge clk_10MHZ); #1;
            start = 1'b0;
        end
        repeat (5) begin @(posedge clk_10MHZ); #1; end
    endtask

    task automatic check_txn(input string name, input logic [79:0] exp_tx, input logic exp_err,
                             input logic [6:0] exp_e, input logic [14:0] exp_m);
        logic [79:0] got;
        got = '0;
        foreach (tx_q[i]) got = {got[71:0], tx_q[i]};
        check({name, "_ntx"}, tx_q.size(), 10);
        check({name, "_tx"}, got, exp_tx);
        check({name, "_hold"}, hold_bad, 1'b0);
        check({name, "_ndone"}, done_q.size(), 1);
        if (done_q.size() > 0)
            check({name, "_result"}, done_q[0], {exp_err, 1'b0, exp_e, exp_m});
    endtask

    task automatic check_addw(input string name);
        if (strobe_q.size() == 10 && fall_q.size() >= 9)
            check(name, strobe_q[9] - fall_q[8], ADD_WAIT);
        else
            check({name, "_strobes"}, strobe_q.size(), 10);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; start = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
        a_e = '0; a_m = '0; b_e = '0; b_m = '0;

        vecs[0] = '{7'h05, 15'h4001, 7'h7F, 15'h7FFF, 8'h83, 8'hAB, 8'hCD,
                    80'h81_05_80_02_82_7F_FF_FE_89_85, 7'h03, 15'h55E6};
        vecs[1] = '{7'h00, 15'h0000, 7'h00, 15'h0000, 8'h00, 8'h00, 8'h00,
                    80'h81_00_00_00_82_00_00_00_89_85, 7'h00, 15'h0000};
        vecs[2] = '{7'h7F, 15'h7FFF, 7'h01, 15'h0001, 8'hFF, 8'hFF, 8'hFF,
                    80'h81_7F_FF_FE_82_01_00_02_89_85, 7'h7F, 15'h7FFF};
        vecs[3] = '{7'h2A, 15'h5555, 7'h15, 15'h2AAA, 8'h80, 8'h01, 8'hFE,
                    80'h81_2A_AA_AA_82_15_55_54_89_85, 7'h00, 15'h00FF};

        repeat (3) @(posedge clk_10MHZ);
        #1;
        check("reset_outputs", {tx_data, tx_start, busy, done, error, res_e, res_m}, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i], 10, 1'b1, 1'b0, 1'b0);
            check_txn($sformatf("table%0d", i), vecs[i].exp_tx, 1'b0, vecs[i].exp_e, vecs[i].exp_m);
            check_addw($sformatf("table%0d_addwait", i));
            last_e = vecs[i].exp_e;
            last_m = vecs[i].exp_m;
        end

        for (int i = 0; i < 12; i++) begin
            v.ae = 7'($urandom); v.am = 15'($urandom); v.be = 7'($urandom); v.bm = 15'($urandom);
            v.r0 = 8'($urandom); v.r1 = 8'($urandom); v.r2 = 8'($urandom);
            v.exp_tx = model_tx(v.ae, v.am, v.be, v.bm);
            {v.exp_e, v.exp_m} = model_res(v.r0, v.r1, v.r2);
            run_txn(v, $urandom_range(1, 12), 1'b1, 1'b0, 1'b0);
            check_txn($sformatf("rand%0d", i), v.exp_tx, 1'b0, v.exp_e, v.exp_m);
            check_addw($sformatf("rand%0d_addwait", i));
            last_e = v.exp_e;
            last_m = v.exp_m;
        end

        // Second start and a stray rx byte while bytes are going out must change nothing.
        run_txn(vecs[0], 10, 1'b1, 1'b1, 1'b0);
        check_txn("disturb", vecs[0].exp_tx, 1'b0, vecs[0].exp_e, vecs[0].exp_m);

        // A start coincident with done must not open a new transaction.
        run_txn(vecs[2], 4, 1'b1, 1'b0, 1'b1);
        check_txn("start_on_done", vecs[2].exp_tx, 1'b0, vecs[2].exp_e, vecs[2].exp_m);
        check("start_on_done_busy", busy, 1'b0);

        // Reset while byte index 5 is in WAIT_DONE, then a full rerun.
        clear_logs();
        busy_len_cfg = 10;
        @(posedge clk_10MHZ); #1;
        a_e = vecs[3].ae; a_m = vecs[3].am; b_e = vecs[3].be; b_m = vecs[3].bm;
        start = 1'b1;
        @(posedge clk_10MHZ); #1;
        start = 1'b0;
        for (int k = 0; k < 2000 && tx_q.size() < 6; k++) begin @(posedge clk_10MHZ); #1; end
        check("rst_mid_reached_byte5", tx_q.size(), 6);
        repeat (3) begin @(posedge clk_10MHZ); #1; end
        rst_n = 1'b0;
        @(posedge clk_10MHZ); #1;
        rst_n = 1'b1;
        check("rst_mid_outputs", {tx_data, tx_start, busy, done, error, res_e, res_m}, '0);
        for (int k = 0; k < 100 && tx_busy; k++) begin @(posedge clk_10MHZ); #1; end
        run_txn(vecs[0], 10, 1'b1, 1'b0, 1'b0);
        check_txn("after_rst", vecs[0].exp_tx, 1'b0, vecs[0].exp_e, vecs[0].exp_m);
        last_e = vecs[0].exp_e;
        last_m = vecs[0].exp_m;

        // No reply after 0x85: RECV is entered on the edge after the fall, then TIMEOUT cycles elapse.
        run_txn(vecs[1], 10, 1'b0, 1'b0, 1'b0);
        check_txn("timeout", vecs[1].exp_tx, 1'b1, last_e, last_m);
        if (done_cyc_q.size() > 0 && fall_q.size() == 10)
            check("timeout_latency", done_cyc_q[0] - fall_q[9], TIMEOUT + 1);
        else
            check("timeout_latency_events", done_cyc_q.size(), 1);
        check("timeout_res_kept", {res_e, res_m}, {last_e, last_m});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
